led_matrix_scan: RTL and testbench

LED_MATRIX_SCAN -- requirements
Module: led_matrix_scan

---
 rtl/led_matrix_pkg.sv | 16 +
 rtl/led_scan_prescaler.sv | 37 +++
 rtl/led_matrix_scan.sv | 143 ++++++++++++++
 tb/tb_led_matrix_scan.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared types and default parameter values for the LED matrix scanner.
package led_matrix_pkg;

  // Scan FSM: blank the matrix between columns, then drive one column.
  typedef enum logic [0:0] {
    StBlank = 1'b0,
    StDrive = 1'b1
  } scan_state_e;

  localparam int unsigned DefRows       = 8;
  localparam int unsigned DefCols       = 4;
  localparam int unsigned DefPwmBits    = 4;
  localparam int unsigned DefScanDiv    = 2;
  localparam int unsigned DefBlankTicks = 1;

endpackage

// File: rtl/led_scan_prescaler.sv
// Divides clk down to one PWM tick every SCAN_DIV enabled cycles.
module led_scan_prescaler
  import led_matrix_pkg::*;
#(
  parameter int unsigned SCAN_DIV = DefScanDiv
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count 0..SCAN_DIV-1 while enabled; hold when disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
    end
  end

  // Prescaler register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == CntLast);

endmodule

// File: rtl/led_matrix_scan.sv
// Multiplexed LED matrix scanner: flop-based frame buffer, per-column PWM drive with
// blanking between columns and a tear-free shadow copy of the active column.
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROWS        = DefRows,
  parameter int unsigned COLS        = DefCols,
  parameter int unsigned PWM_BITS    = DefPwmBits,
  parameter int unsigned SCAN_DIV    = DefScanDiv,
  parameter int unsigned BLANK_TICKS = DefBlankTicks,
  localparam int unsigned Entries    = ROWS * COLS,
  localparam int unsigned AddrW      = (Entries > 1) ? $clog2(Entries) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                wr_en,
  input  logic [AddrW-1:0]    wr_addr,
  input  logic [PWM_BITS-1:0] wr_data,
  output logic [ROWS-1:0]     row,
  output logic [COLS-1:0]     col_n,
  output logic                frame_start
);

  localparam int unsigned ColW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned BlankW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;
  localparam logic [PWM_BITS-1:0] PwmLast   = PWM_BITS'((2 ** PWM_BITS) - 2);
  localparam logic [BlankW-1:0]   BlankLast = BlankW'(BLANK_TICKS - 1);
  localparam logic [ColW-1:0]     ColLast   = ColW'(COLS - 1);

  logic tick;

  scan_state_e         state_q, state_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [BlankW-1:0]   blank_q, blank_d;
  logic [ColW-1:0]     col_q, col_d;
  logic                load;

  logic [PWM_BITS-1:0] fb_q     [Entries];
  logic [PWM_BITS-1:0] shadow_q [ROWS];
  logic [PWM_BITS-1:0] shadow_d [ROWS];

  logic [ROWS-1:0] row_q, row_d;
  logic [COLS-1:0] col_n_q, col_n_d;
  logic            fs_q, fs_d;

  led_scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  // Frame buffer write port; out-of-range addresses are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) fb_q[i] <= '0;
    end else if (wr_en && (32'(wr_addr) < Entries)) begin
      fb_q[wr_addr] <= wr_data;
    end
  end

  // Next-state logic: FSM only moves on ticks, so enable low freezes everything.
  always_comb begin
    state_d = state_q;
    pwm_d   = pwm_q;
    blank_d = blank_q;
    col_d   = col_q;
    load    = 1'b0;
    if (tick) begin
      unique case (state_q)
        StDrive: begin
          if (pwm_q == PwmLast) begin
            state_d = StBlank;
            pwm_d   = '0;
          end else begin
            pwm_d = pwm_q + 1'b1;
          end
        end
        StBlank: begin
          if (blank_q == BlankLast) begin
            state_d = StDrive;
            blank_d = '0;
            col_d   = (col_q == ColLast) ? '0 : col_q + 1'b1;
            load    = 1'b1;
          end else begin
            blank_d = blank_q + 1'b1;
          end
        end
        default: state_d = StBlank;
      endcase
    end
  end

  // Shadow capture reads the pre-write buffer, so a same-edge write lands next frame.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      shadow_d[r] = load ? fb_q[AddrW'(int'(col_d) * int'(ROWS) + r)] : shadow_q[r];
    end
  end

  // Output decode from next state so outputs change on the same edge as the counters.
  always_comb begin
    row_d   = '0;
    col_n_d = '1;
    fs_d    = 1'b0;
    if (enable && (state_d == StDrive)) begin
      for (int r = 0; r < ROWS; r++) row_d[r] = (pwm_d < shadow_d[r]);
      col_n_d[col_d] = 1'b0;
      fs_d           = load && (col_d == '0);
    end
  end

  // Scan state, shadow and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StBlank;
      pwm_q   <= '0;
      blank_q <= '0;
      col_q   <= ColLast;
      for (int r = 0; r < ROWS; r++) shadow_q[r] <= '0;
      row_q   <= '0;
      col_n_q <= '1;
      fs_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwm_q    <= pwm_d;
      blank_q  <= blank_d;
      col_q    <= col_d;
      shadow_q <= shadow_d;
      row_q    <= row_d;
      col_n_q  <= col_n_d;
      fs_q     <= fs_d;
    end
  end

  assign row         = row_q;
  assign col_n       = col_n_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Bench for led_matrix_scan: timeline model of the scan plus directed literal checks.
module tb_led_matrix_scan;

  localparam int R  = 8;
  localparam int C  = 4;
  localparam int D  = 2;
  localparam int BT = 1;
  localparam int DR = 15;       // drive ticks per column
  localparam int P  = DR + BT;  // ticks per column period

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [7:0] row;
  logic [3:0] col_n;
  logic       frame_start;

  // Small second instance: non-power-of-two buffer, SCAN_DIV=1, two blank ticks.
  logic       s_rst = 1'b1;
  logic       s_wr_en = 1'b0;
  logic [2:0] s_wr_addr = '0;
  logic [1:0] s_wr_data = '0;
  logic [2:0] s_row;
  logic [1:0] s_col_n;
  logic       s_fs;

  int errors = 0;
  int checks = 0;
  int cyc;

  always #5 clk = ~clk;

  led_matrix_scan dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .row         (row),
    .col_n       (col_n),
    .frame_start (frame_start)
  );

  led_matrix_scan #(
    .ROWS        (3),
    .COLS        (2),
    .PWM_BITS    (2),
    .SCAN_DIV    (1),
    .BLANK_TICKS (2)
  ) dut_small (
    .clk         (clk),
    .rst         (s_rst),
    .enable      (1'b1),
    .wr_en       (s_wr_en),
    .wr_addr     (s_wr_addr),
    .wr_data     (s_wr_data),
    .row         (s_row),
    .col_n       (s_col_n),
    .frame_start (s_fs)
  );

  // Edges since reset release, used to place directed stimulus.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Timeline model: after e enabled edges, e/D ticks have elapsed; the first BT ticks are
  // the initial blank, then each column period is DR drive ticks followed by BT blank ticks.
  logic [7:0] exp_row;
  logic [3:0] exp_col;
  logic       exp_fs;
  int         e;
  int         mbuf [R*C];
  int         msh  [R];

  initial begin
    int n, m, ph, c;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        e = 0;
        for (int i = 0; i < R*C; i++) mbuf[i] = 0;
        for (int i = 0; i < R; i++) msh[i] = 0;
        exp_row = '0;
        exp_col = '1;
        exp_fs  = 1'b0;
      end else begin
        exp_row = '0;
        exp_col = '1;
        exp_fs  = 1'b0;
        if (enable) begin
          e++;
          n = e / D;
          if (n >= BT) begin
            m  = n - BT;
            ph = m % P;
            c  = (m / P) % C;
            if ((e % D) == 0 && ph == 0) begin
              for (int r = 0; r < R; r++) msh[r] = mbuf[c*R + r];
            end
            if (ph < DR) begin
              for (int r = 0; r < R; r++) begin
                if (ph < msh[r]) exp_row = exp_row | (8'd1 << r);
              end
              exp_col = ~(4'b0001 << c);
              exp_fs  = ((e % D) == 0) && (ph == 0) && (c == 0);
            end
          end
        end
        if (wr_en && int'(wr_addr) < R*C) mbuf[int'(wr_addr)] = int'(wr_data);
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, got, want, cyc);
    end
  endtask

  // One clock: compare against the model on the falling edge, then move off the edge.
  task automatic step();
    @(negedge clk);
    checks++;
    if (row !== exp_row || col_n !== exp_col || frame_start !== exp_fs) begin
      errors++;
      $display("FAIL model cyc=%0d row=%h want %h col_n=%b want %b fs=%b want %b",
               cyc, row, exp_row, col_n, exp_col, frame_start, exp_fs);
    end
    #1;
  endtask

  task automatic wait_until(input int k);
    int guard;
    guard = 0;
    while (cyc < k && guard < 2000) begin
      step();
      guard++;
    end
    chk("wait_bound", longint'(cyc >= k), 1);
  endtask

  initial begin
    int fs_cnt, row_any, r0, r1, cnt, other;

    // Reset state.
    repeat (3) step();
    chk("rst_row", row, 0);
    chk("rst_col_n", col_n, 4'hF);
    chk("rst_fs", frame_start, 0);
    rst   = 1'b0;
    s_rst = 1'b0;

    // Empty buffer: columns rotate every 32 clk, frame_start once per 128.
    fs_cnt  = 0;
    row_any = 0;
    for (int k = 1; k <= 130; k++) begin
      step();
      if (cyc == 2)   begin chk("c0_col", col_n, 4'b1110); chk("c0_fs", frame_start, 1); end
      if (cyc == 3)   chk("fs_one_cycle", frame_start, 0);
      if (cyc == 32)  chk("blank_col", col_n, 4'b1111);
      if (cyc == 34)  chk("c1_col", col_n, 4'b1101);
      if (cyc == 66)  chk("c2_col", col_n, 4'b1011);
      if (cyc == 98)  chk("c3_col", col_n, 4'b0111);
      if (cyc == 130) begin chk("wrap_col", col_n, 4'b1110); chk("wrap_fs", frame_start, 1); end
      if (cyc >= 2 && cyc <= 129 && frame_start) fs_cnt++;
      if (row != 0) row_any++;
    end
    chk("fs_per_frame", fs_cnt, 1);
    chk("row_zero", row_any, 0);

    // Full and half brightness on column 0.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 4'hF;
    step();
    wr_addr = 5'd1; wr_data = 4'h8;
    step();
    wr_en = 1'b0;
    wait_until(257);
    r0 = 0; r1 = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      r0 += int'(row[0]);
      r1 += int'(row[1]);
    end
    chk("full_bright_clk", r0, 30);
    chk("half_bright_clk", r1, 16);
    step();
    chk("drive_end_row", row, 0);

    // Write landing on the edge column 1 is captured.
    wait_until(289);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 4'h5;
    step();
    wr_en = 1'b0;
    cnt = int'(row[1]);
    for (int k = 0; k < 29; k++) begin
      step();
      cnt += int'(row[1]);
    end
    chk("collide_old_value", cnt, 0);
    wait_until(417);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      cnt += int'(row[1]);
    end
    chk("collide_next_frame", cnt, 10);

    // Freeze mid-drive for 50 clk, then resume with the same remainder.
    wait_until(520);
    chk("pre_freeze_row0", row[0], 1);
    chk("pre_freeze_col", col_n, 4'b1110);
    enable = 1'b0;
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (row != 0 || col_n != 4'hF) cnt++;
    end
    chk("frozen_blank", cnt, 0);
    enable = 1'b1;
    cnt = 0;
    r0  = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (col_n == 4'b1110) cnt++;
      r0 += int'(row[0]);
    end
    chk("resume_remainder", cnt, 23);
    chk("resume_row0", r0, 23);

    // Asynchronous reset mid-drive clears outputs and buffer.
    wait_until(700);
    chk("pre_rst_row0", row[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_row", row, 0);
    chk("async_rst_col", col_n, 4'hF);
    chk("async_rst_fs", frame_start, 0);
    step();
    rst = 1'b0;
    row_any = 0;
    for (int k = 0; k < 130; k++) begin
      step();
      if (cyc == 2) chk("post_rst_c0", col_n, 4'b1110);
      if (row != 0) row_any++;
    end
    chk("post_rst_buffer_zero", row_any, 0);

    // Small instance: out-of-range writes ignored, valid write shows up.
    s_wr_en = 1'b1; s_wr_addr = 3'd6; s_wr_data = 2'd3;
    step();
    s_wr_addr = 3'd7;
    step();
    s_wr_addr = 3'd4; s_wr_data = 2'd2;
    step();
    s_wr_en = 1'b0;
    repeat (10) step();
    r1 = 0; other = 0; fs_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      r1 += int'(s_row[1]);
      other += int'(s_row[0]) + int'(s_row[2]);
      fs_cnt += int'(s_fs);
    end
    chk("small_row1_clk", r1, 4);
    chk("small_oob_ignored", other, 0);
    chk("small_fs_cnt", fs_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
